// File: rtl/adder_pkg.sv
// Shared constants, field layout and result record for the conditional-sum adder.
package adder_pkg;

  localparam int WIDTH_DEFAULT = 16;

  // Width of the packed {p, g, s, t} result for an operand width w.
  function automatic int RES_W(input int w);
    return 2 * w + 2;
  endfunction

  // Field positions inside the packed result at the default width.
  localparam int P_BIT = 2 * WIDTH_DEFAULT + 1;
  localparam int G_BIT = 2 * WIDTH_DEFAULT;
  localparam int S_LSB = WIDTH_DEFAULT;
  localparam int T_LSB = 0;

  // Packed result record at the default width; member order matches the res bus.
  typedef struct packed {
    logic                     p;
    logic                     g;
    logic [WIDTH_DEFAULT-1:0] s;
    logic [WIDTH_DEFAULT-1:0] t;
  } adder_res_t;

endpackage

// File: rtl/adder_node.sv
// Conditional-sum combine: merges a high and a low half-width result into one
// full-width result (both sum candidates plus block generate/propagate).
module adder_node
  import adder_pkg::*;
#(
  parameter int HW = 1
) (
  input  logic [HW-1:0]   h_t,
  input  logic [HW-1:0]   h_s,
  input  logic            h_g,
  input  logic            h_p,
  input  logic [HW-1:0]   l_t,
  input  logic [HW-1:0]   l_s,
  input  logic            l_g,
  input  logic            l_p,
  output logic [2*HW-1:0] t,
  output logic [2*HW-1:0] s,
  output logic            g,
  output logic            p
);

  // The low half's carry-out (without / with carry-in) picks the high half's sum.
  always_comb begin
    t = {(l_g ? h_s : h_t), l_t};
    s = {((l_g | l_p) ? h_s : h_t), l_s};
    g = h_g | (h_p & l_g);
    p = h_p & l_p;
  end

endmodule

// File: rtl/adder.sv
// Registered conditional-sum adder: res = {p, g, a+b+1, a+b}, one-cycle latency.
module adder
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      guard,
  output logic [RES_W(WIDTH)-1:0]   res,
  input  logic [WIDTH-1:0]          a,
  input  logic [WIDTH-1:0]          b
);

  localparam int LVL   = $clog2(WIDTH);
  localparam int NODES = 2 * WIDTH - 1;

  // Per-level sum candidates: every level covers the full operand width,
  // split into WIDTH>>k blocks of 2^k bits.
  logic [WIDTH-1:0] t_all [0:LVL];
  logic [WIDTH-1:0] s_all [0:LVL];
  // Generate/propagate of every tree node, level by level (leaves first,
  // root last at index NODES-1).
  logic [NODES-1:0] g_all;
  logic [NODES-1:0] p_all;

  logic [RES_W(WIDTH)-1:0] res_d, res_q;
  logic                    guard_d, guard_q;

  for (genvar k = 0; k <= LVL; k++) begin : g_lvl
    localparam int NN   = WIDTH >> k;
    localparam int NW   = 1 << k;
    localparam int BASE = 2 * WIDTH - 2 * (WIDTH >> k);
    if (k == 0) begin : g_leaf
      assign t_all[0]           = a ^ b;
      assign s_all[0]           = ~(a ^ b);
      assign g_all[WIDTH-1:0]   = a & b;
      assign p_all[WIDTH-1:0]   = a ^ b;
    end else begin : g_tree
      localparam int PBASE = 2 * WIDTH - 2 * (WIDTH >> (k - 1));
      for (genvar j = 0; j < NN; j++) begin : g_node
        adder_node #(.HW(NW / 2)) u_node (
          .h_t (t_all[k-1][(2*j+1)*(NW/2) +: NW/2]),
          .h_s (s_all[k-1][(2*j+1)*(NW/2) +: NW/2]),
          .h_g (g_all[PBASE + 2*j + 1]),
          .h_p (p_all[PBASE + 2*j + 1]),
          .l_t (t_all[k-1][(2*j)*(NW/2) +: NW/2]),
          .l_s (s_all[k-1][(2*j)*(NW/2) +: NW/2]),
          .l_g (g_all[PBASE + 2*j]),
          .l_p (p_all[PBASE + 2*j]),
          .t   (t_all[k][j*NW +: NW]),
          .s   (s_all[k][j*NW +: NW]),
          .g   (g_all[BASE + j]),
          .p   (p_all[BASE + j])
        );
      end
    end
  end

  // Next-state: pack the tree root into {p, g, s, t}; guard goes high after reset.
  always_comb begin
    res_d   = {p_all[NODES-1], g_all[NODES-1], s_all[LVL], t_all[LVL]};
    guard_d = 1'b1;
  end

  // Output register and guard flop; reset clears both immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      guard_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      guard_q <= guard_d;
    end
  end

  assign res   = res_q;
  assign guard = guard_q;

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: reset behaviour, directed corner cases,
// random back-to-back traffic and a full operand sweep with a mid-sweep reset.
module tb_adder;
  import adder_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        guard;
  logic [33:0] res;
  logic [15:0] a;
  logic [15:0] b;

  int checks;
  int errors;

  adder #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .guard (guard),
    .res   (res),
    .a     (a),
    .b     (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the operands.
  function automatic adder_res_t model(input logic [15:0] x, input logic [15:0] y);
    adder_res_t r;
    int unsigned sum0;
    int unsigned sum1;
    sum0 = int'(x) + int'(y);
    sum1 = int'(x) + int'(y) + 1;
    r.t = sum0[15:0];
    r.s = sum1[15:0];
    r.g = (sum0 > 32'd65535);
    r.p = ((x ^ y) == 16'hFFFF);
    return r;
  endfunction

  task automatic test_reset();
    adder_res_t exp;
    rst_n = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    #3;
    checks++;
    if (res !== 34'd0 || guard !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: res=%h guard=%b, want res=0 guard=0", res, guard);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      a = 16'($urandom);
      b = 16'($urandom);
      checks++;
      if (res !== 34'd0 || guard !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: res=%h guard=%b, want res=0 guard=0", res, guard);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    a = 16'($urandom);
    b = 16'($urandom);
    exp = model(a, b);
    #1;
    checks++;
    if (guard !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_early: guard=%b, want 0", guard);
    end
    @(posedge clk);
    #1;
    checks++;
    if (guard !== 1'b1 || res !== 34'(exp)) begin
      errors++;
      $display("FAIL reset_first_result: res=%h guard=%b, want res=%h guard=1", res, guard, 34'(exp));
    end
  endtask

  task automatic test_directed();
    logic [15:0] da [4];
    logic [15:0] db [4];
    logic [33:0] dx [4];
    da[0] = 16'h0000; db[0] = 16'h0001; dx[0] = {1'b0, 1'b0, 16'h0002, 16'h0001};
    da[1] = 16'hFFFF; db[1] = 16'h0001; dx[1] = {1'b0, 1'b1, 16'h0001, 16'h0000};
    da[2] = 16'hAAAA; db[2] = 16'h5555; dx[2] = {1'b1, 1'b0, 16'h0000, 16'hFFFF};
    da[3] = 16'hFFFF; db[3] = 16'hFFFF; dx[3] = {1'b0, 1'b1, 16'hFFFF, 16'hFFFE};
    for (int i = 0; i < 4; i++) begin
      a = da[i];
      b = db[i];
      @(posedge clk);
      #1;
      checks++;
      if (res !== dx[i] || guard !== 1'b1) begin
        errors++;
        $display("FAIL directed_%0d: a=%h b=%h res=%h guard=%b, want res=%h guard=1",
                 i, da[i], db[i], res, guard, dx[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    adder_res_t exp;
    for (int i = 0; i < 400; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 8 == 0) b = ~a;
      exp = model(a, b);
      @(posedge clk);
      #1;
      checks++;
      if (res !== 34'(exp) || guard !== 1'b1) begin
        errors++;
        if (errors < 20)
          $display("FAIL random: a=%h b=%h res=%h guard=%b, want res=%h guard=1",
                   a, b, res, guard, 34'(exp));
      end
    end
  endtask

  task automatic test_sweep();
    adder_res_t exp;
    for (int i = 0; i < 65536; i++) begin
      a = i[15:0];
      b = 16'd1 << (i % 16);
      exp = model(a, b);
      @(posedge clk);
      #1;
      checks++;
      if (res !== 34'(exp) || guard !== 1'b1) begin
        errors++;
        if (errors < 20)
          $display("FAIL sweep: a=%h b=%h res=%h guard=%b, want res=%h guard=1",
                   a, b, res, guard, 34'(exp));
      end
      if (i == 30000) begin
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (res !== 34'd0 || guard !== 1'b0) begin
          errors++;
          $display("FAIL sweep_reset_async: res=%h guard=%b, want res=0 guard=0", res, guard);
        end
        @(posedge clk);
        #1;
        checks++;
        if (res !== 34'd0 || guard !== 1'b0) begin
          errors++;
          $display("FAIL sweep_reset_hold: res=%h guard=%b, want res=0 guard=0", res, guard);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (guard !== 1'b0) begin
          errors++;
          $display("FAIL sweep_reset_release: guard=%b, want 0", guard);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    a      = 16'd0;
    b      = 16'd0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder.md
# adder

Registered 16-bit conditional-sum adder. Each cycle it computes both the sum without carry-in and the sum with carry-in of two operands. It also produces the block-level generate and propagate bits and presents all four, packed, on one output bus with a valid guard. It is the leaf arithmetic block: a surrounding datapath selects between the two sums and chains the generate/propagate pair into wider adders.

## Interface
Parameters:
- WIDTH, default 16: operand width; must be a power of two, at least 2.

Ports:
- clk, input, 1: single clock; rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- guard, output, 1: high when res holds a valid result.
- res, output, 2*WIDTH+2 (34 at the default width): packed result {p, g, s, t}.
- a, input, WIDTH: operand A.
- b, input, WIDTH: operand B.

## Operation
Field layout of res at the default width:
- res[33] = p, propagate: &(a ^ b). A carry-in passes through the whole block.
- res[32] = g, generate: carry-out of a + b with carry-in 0.
- res[31:16] = s: (a + b + 1) mod 2^WIDTH.
- res[15:0] = t: (a + b) mod 2^WIDTH.

Arithmetic rules:
- Carry-out of a + b + 1 equals g | p; it is not output separately.
- p and g are never both 1.
- All arithmetic is unsigned and wraps modulo 2^WIDTH.

Computation is a conditional-sum tree. Leaf cell per bit i:
- t = a^b, s = ~(a^b), g = a&b, p = a^b.

A node combines a high half H and a low half L:
- t = {L.g ? H.s : H.t, L.t}
- s = {(L.g | L.p) ? H.s : H.t, L.s}
- g = H.g | (H.p & L.g)
- p = H.p & L.p
- The tree depth is log2(WIDTH).

## Timing
- Reset: while rst_n is low, res = 0 and guard = 0, regardless of clk.
- At each rising clk edge with rst_n high:
  - res <= f(a, b) from the operand values at that edge.
  - guard <= 1.
- Latency is 1 cycle, one new result every cycle, with no back-pressure.
- guard first rises on the first clock edge after rst_n deasserts and stays high until the next reset.
- Reset asserted mid-operation clears res and guard immediately. The in-flight result is discarded.
- There are no combinational paths from a or b to the outputs.

## Structure
- A shared package holds:
  - WIDTH_DEFAULT = 16
  - RES_W(w) = 2*w + 2
  - Field index constants P_BIT, G_BIT, S_LSB, T_LSB
  - A typedef adder_res_t for the packed {p, g, s, t} record.
- A natural sub-module is adder_node: the combinational combine of two half-width results into one full-width result.
- The top level contains:
  - the generate loop over the tree levels (leaf cells inline, adder_node instances above them);
  - the output register and the guard flop.

## Test plan
- Reset: hold rst_n low with random a/b and toggle clk -> res = 0, guard = 0. Release rst_n -> guard = 1 one edge later.
- a=0x0000, b=0x0001 -> t=0x0001, s=0x0002, g=0, p=0; res = 0x0_0002_0001 one cycle later.
- a=0xFFFF, b=0x0001 -> t=0x0000, s=0x0001, g=1, p=0.
- a=0xAAAA, b=0x5555 -> t=0xFFFF, s=0x0000, g=0, p=1.
- a=0xFFFF, b=0xFFFF -> t=0xFFFE, s=0xFFFF, g=1, p=0.
- Sweep:
  - a increments every cycle over 0..0xFFFF; b steps through 1<<k, k=0..15.
  - Check each result against a reference model: t = a+b, s = a+b+1, g = carry-out of a+b, p = &(a^b).
  - Also assert reset mid-sweep; res and guard must clear asynchronously.
